// File: rtl/call_stack.sv
// call_stack: parametrised return-address stack for the TB4004 core.
//   CALL pushes the return PC, RET pops it, CALL+RET together replaces the top.
//   WRAP_MODE selects the full-stack policy: 0 rejects the push, 1 overwrites
//   the oldest entry (original 4004 behaviour).
// Ports:
//   clk, rstN          rising-edge clock, asynchronous active-low reset
//   push, pop          decoder requests for this cycle
//   flush              synchronous empty (mem contents are left in place)
//   errClr             clears sticky overflow/underflow
//   pcIn               return PC to push
//   pcOut, popValid    registered pop result, valid the cycle after pop
//   topOut             combinational top entry, 0 when empty
//   count, full, empty occupancy
//   overflow, underflow sticky error flags
module call_stack #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 0,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             errClr,
    input  logic [WIDTH-1:0] pcIn,
    output logic [WIDTH-1:0] pcOut,
    output logic             popValid,
    output logic [WIDTH-1:0] topOut,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    topPtr;
    logic [PW-1:0]    nextPtr;
    logic             memWe;
    logic [PW-1:0]    memAddr;
    logic             overflowSet;
    logic             underflowSet;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_comb begin
        topPtr  = (wrPtr == '0) ? PW'(DEPTH - 1) : wrPtr - PW'(1);
        nextPtr = (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
    end

    // Gate the read so an empty stack never exposes stale mem contents.
    assign topOut = empty ? '0 : mem[topPtr];

    // Write port: a replace (push+pop on a non-empty stack) rewrites the top
    // slot; every other accepted push lands at wrPtr. A push+pop on an empty
    // stack falls through to the ordinary push path.
    always_comb begin
        memWe   = 1'b0;
        memAddr = wrPtr;
        if (!flush) begin
            if (push && pop && !empty) begin
                memWe   = 1'b1;
                memAddr = topPtr;
            end else if (push && (!full || (WRAP_MODE != 0) || pop)) begin
                memWe   = 1'b1;
                memAddr = wrPtr;
            end
        end
    end

    // Error events; a replace never overflows because occupancy is unchanged.
    always_comb begin
        overflowSet  = !flush && push && !pop && full;
        underflowSet = !flush && pop && empty;
    end

    // Storage array.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (memWe) begin
            mem[memAddr] <= pcIn;
        end
    end

    // Pointer, count and pop-result registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr    <= '0;
            count    <= '0;
            pcOut    <= '0;
            popValid <= 1'b0;
        end else begin
            popValid <= 1'b0;
            if (flush) begin
                wrPtr <= '0;
                count <= '0;
                pcOut <= '0;
            end else if (push && pop) begin
                if (!empty) begin
                    pcOut    <= mem[topPtr];
                    popValid <= 1'b1;
                end else begin
                    pcOut <= '0;
                    wrPtr <= nextPtr;
                    count <= CW'(1);
                end
            end else if (push) begin
                if (!full) begin
                    wrPtr <= nextPtr;
                    count <= count + CW'(1);
                end else if (WRAP_MODE != 0) begin
                    wrPtr <= nextPtr;
                end
            end else if (pop) begin
                if (!empty) begin
                    pcOut    <= mem[topPtr];
                    popValid <= 1'b1;
                    wrPtr    <= topPtr;
                    count    <= count - CW'(1);
                end else begin
                    pcOut <= '0;
                end
            end
        end
    end

    // Sticky flags: a new error in the same cycle as errClr wins.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflowSet  | (overflow  & ~errClr);
            underflow <= underflowSet | (underflow & ~errClr);
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: scoreboard bench for call_stack (WIDTH=12, DEPTH=8).
//   dut0 runs with WRAP_MODE=0, dut1 with WRAP_MODE=1. Expected pop data is
//   queued when a pop is issued; a negedge monitor pops and compares whenever
//   popValid is seen. State outputs are compared directly after each step.
module tb_call_stack;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        push   [2];
    logic        pop    [2];
    logic        flush  [2];
    logic        errClr [2];
    logic [11:0] pcIn   [2];
    logic [11:0] pcOut  [2];
    logic        popValid [2];
    logic [11:0] topOut [2];
    logic [3:0]  count  [2];
    logic        full   [2];
    logic        empty  [2];
    logic        overflow  [2];
    logic        underflow [2];

    logic [11:0] expQ0 [$];
    logic [11:0] expQ1 [$];
    int passCount = 0;
    int totalCount = 0;

    always #5 clk = ~clk;

    call_stack #(.WIDTH(12), .DEPTH(8), .WRAP_MODE(0)) dut0 (
        .clk(clk), .rstN(rstN), .push(push[0]), .pop(pop[0]), .flush(flush[0]),
        .errClr(errClr[0]), .pcIn(pcIn[0]), .pcOut(pcOut[0]), .popValid(popValid[0]),
        .topOut(topOut[0]), .count(count[0]), .full(full[0]), .empty(empty[0]),
        .overflow(overflow[0]), .underflow(underflow[0])
    );

    call_stack #(.WIDTH(12), .DEPTH(8), .WRAP_MODE(1)) dut1 (
        .clk(clk), .rstN(rstN), .push(push[1]), .pop(pop[1]), .flush(flush[1]),
        .errClr(errClr[1]), .pcIn(pcIn[1]), .pcOut(pcOut[1]), .popValid(popValid[1]),
        .topOut(topOut[1]), .count(count[1]), .full(full[1]), .empty(empty[1]),
        .overflow(overflow[1]), .underflow(underflow[1])
    );

    task automatic checkOutput(input string name, input int sel,
                               input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t",
                     name, sel, actual, expected, $time);
        end
    endtask

    task automatic clearInputs();
        for (int s = 0; s < 2; s++) begin
            push[s]   = 1'b0;
            pop[s]    = 1'b0;
            flush[s]  = 1'b0;
            errClr[s] = 1'b0;
            pcIn[s]   = '0;
        end
    endtask

    // Drive one cycle of requests on the selected DUT; queue the pop data we expect.
    task automatic applyStimulus(input int sel, input bit doPush, input bit doPop,
                                 input bit doFlush, input bit doClr,
                                 input logic [11:0] data,
                                 input bit expValid, input logic [11:0] expData);
        @(negedge clk);
        clearInputs();
        push[sel]   = doPush;
        pop[sel]    = doPop;
        flush[sel]  = doFlush;
        errClr[sel] = doClr;
        pcIn[sel]   = data;
        if (expValid) begin
            if (sel == 0) expQ0.push_back(expData);
            else          expQ1.push_back(expData);
        end
    endtask

    // Let the last request take effect, leaving inputs idle.
    task automatic settle();
        @(negedge clk);
        clearInputs();
    endtask

    task automatic scoreboardCheck(input int sel, input logic [11:0] got);
        logic [11:0] exp;
        if ((sel == 0 && expQ0.size() == 0) || (sel == 1 && expQ1.size() == 0)) begin
            totalCount++;
            $display("[TB] FAIL popUnexpected dut%0d: got popValid=1 pcOut=0x%0h, expected no pop at %0t",
                     sel, got, $time);
        end else begin
            exp = (sel == 0) ? expQ0.pop_front() : expQ1.pop_front();
            checkOutput("popData", sel, {20'd0, got}, {20'd0, exp});
        end
    endtask

    // Monitor: every popValid pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rstN) begin
            if (popValid[0] === 1'b1) scoreboardCheck(0, pcOut[0]);
            if (popValid[1] === 1'b1) scoreboardCheck(1, pcOut[1]);
        end
    end

    initial begin
        clearInputs();
        #12 rstN = 1'b1;

        // Reset state
        settle();
        for (int s = 0; s < 2; s++) begin
            checkOutput("rstCount", s, 32'(count[s]), 32'd0);
            checkOutput("rstEmpty", s, 32'(empty[s]), 32'd1);
            checkOutput("rstTop", s, 32'(topOut[s]), 32'd0);
            checkOutput("rstFlags", s, {30'd0, overflow[s], underflow[s]}, 32'd0);
        end

        // 1: fill then drain in LIFO order
        for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 0, 0, 0, 12'(32'h100 + i), 0, '0);
        settle();
        checkOutput("t1Full", 0, 32'(full[0]), 32'd1);
        checkOutput("t1Count", 0, 32'(count[0]), 32'd8);
        checkOutput("t1Top", 0, 32'(topOut[0]), 32'h108);
        for (int i = 8; i >= 1; i--) applyStimulus(0, 0, 1, 0, 0, '0, 1, 12'(32'h100 + i));
        settle();
        checkOutput("t1Empty", 0, 32'(empty[0]), 32'd1);
        checkOutput("t1Flags", 0, {30'd0, overflow[0], underflow[0]}, 32'd0);

        // 2: reject-on-full
        for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 0, 0, 0, 12'(32'h100 + i), 0, '0);
        applyStimulus(0, 1, 0, 0, 0, 12'h1FF, 0, '0);
        settle();
        checkOutput("t2Overflow", 0, 32'(overflow[0]), 32'd1);
        checkOutput("t2Count", 0, 32'(count[0]), 32'd8);
        checkOutput("t2Top", 0, 32'(topOut[0]), 32'h108);
        applyStimulus(0, 0, 1, 0, 0, '0, 1, 12'h108);
        settle();
        checkOutput("t2PcOut", 0, 32'(pcOut[0]), 32'h108);
        applyStimulus(0, 0, 0, 0, 1, '0, 0, '0);
        settle();
        checkOutput("t2ErrClr", 0, 32'(overflow[0]), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, '0, 0, '0);
        settle();
        checkOutput("t2Flush", 0, 32'(count[0]), 32'd0);

        // 3: circular overwrite on dut1
        for (int i = 1; i <= 9; i++) applyStimulus(1, 1, 0, 0, 0, 12'(32'h100 + i), 0, '0);
        settle();
        checkOutput("t3Overflow", 1, 32'(overflow[1]), 32'd1);
        checkOutput("t3Count", 1, 32'(count[1]), 32'd8);
        checkOutput("t3Top", 1, 32'(topOut[1]), 32'h109);
        for (int i = 9; i >= 2; i--) applyStimulus(1, 0, 1, 0, 0, '0, 1, 12'(32'h100 + i));
        applyStimulus(1, 0, 1, 0, 0, '0, 0, '0);
        settle();
        checkOutput("t3PcOut", 1, 32'(pcOut[1]), 32'd0);
        checkOutput("t3PopValid", 1, 32'(popValid[1]), 32'd0);
        checkOutput("t3Underflow", 1, 32'(underflow[1]), 32'd1);
        checkOutput("t3Empty", 1, 32'(empty[1]), 32'd1);

        // 4: replace, and push+pop on empty
        applyStimulus(0, 1, 0, 0, 0, 12'h0AA, 0, '0);
        applyStimulus(0, 1, 1, 0, 0, 12'h0BB, 1, 12'h0AA);
        settle();
        checkOutput("t4PcOut", 0, 32'(pcOut[0]), 32'h0AA);
        checkOutput("t4PopValid", 0, 32'(popValid[0]), 32'd1);
        checkOutput("t4Count", 0, 32'(count[0]), 32'd1);
        checkOutput("t4Top", 0, 32'(topOut[0]), 32'h0BB);
        applyStimulus(0, 0, 1, 0, 0, '0, 1, 12'h0BB);
        applyStimulus(0, 1, 1, 0, 0, 12'h0CC, 0, '0);
        settle();
        checkOutput("t4EmptyUnderflow", 0, 32'(underflow[0]), 32'd1);
        checkOutput("t4EmptyCount", 0, 32'(count[0]), 32'd1);
        checkOutput("t4EmptyTop", 0, 32'(topOut[0]), 32'h0CC);
        checkOutput("t4EmptyPopValid", 0, 32'(popValid[0]), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, '0, 1, 12'h0CC);
        applyStimulus(0, 0, 1, 0, 1, '0, 0, '0);
        settle();
        checkOutput("t4SetBeatsClr", 0, 32'(underflow[0]), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, '0, 0, '0);
        settle();
        checkOutput("t4Clr", 0, 32'(underflow[0]), 32'd0);

        // 5: flush beats push
        for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 0, 0, 0, 12'(32'h200 + i), 0, '0);
        applyStimulus(0, 1, 0, 1, 0, 12'h2FF, 0, '0);
        settle();
        checkOutput("t5Count", 0, 32'(count[0]), 32'd0);
        checkOutput("t5Empty", 0, 32'(empty[0]), 32'd1);
        checkOutput("t5Top", 0, 32'(topOut[0]), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, '0, 0, '0);
        settle();
        checkOutput("t5Underflow", 0, 32'(underflow[0]), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, '0, 0, '0);

        // Replace while full raises no overflow
        for (int i = 1; i <= 8; i++) applyStimulus(0, 1, 0, 0, 0, 12'(32'h300 + i), 0, '0);
        applyStimulus(0, 1, 1, 0, 0, 12'h3AA, 1, 12'h308);
        settle();
        checkOutput("fullReplaceOvf", 0, 32'(overflow[0]), 32'd0);
        checkOutput("fullReplaceCount", 0, 32'(count[0]), 32'd8);
        checkOutput("fullReplaceTop", 0, 32'(topOut[0]), 32'h3AA);

        // 6: async reset mid-sequence (count=5, overflow=1)
        applyStimulus(0, 1, 0, 0, 0, 12'h3FF, 0, '0);
        applyStimulus(0, 0, 1, 0, 0, '0, 1, 12'h3AA);
        applyStimulus(0, 0, 1, 0, 0, '0, 1, 12'h307);
        applyStimulus(0, 0, 1, 0, 0, '0, 1, 12'h306);
        settle();
        checkOutput("t6PreCount", 0, 32'(count[0]), 32'd5);
        checkOutput("t6PreOverflow", 0, 32'(overflow[0]), 32'd1);
        @(posedge clk);
        #3 rstN = 1'b0;
        #1;
        checkOutput("t6Count", 0, 32'(count[0]), 32'd0);
        checkOutput("t6Top", 0, 32'(topOut[0]), 32'd0);
        checkOutput("t6PcOut", 0, 32'(pcOut[0]), 32'd0);
        checkOutput("t6Bits", 0, {28'd0, popValid[0], overflow[0], underflow[0], full[0]}, 32'd0);
        checkOutput("t6Empty", 0, 32'(empty[0]), 32'd1);
        #4 rstN = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 12'h123, 0, '0);
        settle();
        checkOutput("t6PostTop", 0, 32'(topOut[0]), 32'h123);
        checkOutput("t6PostCount", 0, 32'(count[0]), 32'd1);

        // Every queued pop must have been seen by the monitor
        settle();
        checkOutput("scoreboardDrain", 0, 32'(expQ0.size()), 32'd0);
        checkOutput("scoreboardDrain", 1, 32'(expQ1.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
